// File: rtl/upuart_pkg.sv
// Shared definitions for the UART transmit controller: state encoding,
// default widths, and a bit-index width helper.
`timescale 1ns/1ps
package upuart_pkg;

   localparam int UPUART_FIFO_WIDTH  = 8;
   localparam int UPUART_DIVDR_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } upuart_tx_state_t;

   // Width of a bit index able to address w positions (at least one bit).
   function automatic int idx_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/upuart_baud_tick.sv
// Bit-period down-counter: loads a period value at the start of each bit
// and counts down to zero; o_tick marks the final cycle of the bit.
`timescale 1ns/1ps
module upuart_baud_tick
   import upuart_pkg::*;
#(
   parameter int CNT_W = UPUART_DIVDR_WIDTH
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_cnt;

   // Reload at each bit start, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/upuart_tx_ctrl.sv
// UART transmit controller fed by a first-word fall-through FIFO.
// Frame: start bit, FIFO_WIDTH data bits LSB first, optional even parity,
// one stop bit. Back-to-back characters are sent with no idle gap.
// Optional feature: define UPUART_TX_PARITY_EN to insert an even parity bit.
`timescale 1ns/1ps
module upuart_tx_ctrl
   import upuart_pkg::*;
#(
   parameter int FIFO_WIDTH  = UPUART_FIFO_WIDTH,
   parameter int DIVDR_WIDTH = UPUART_DIVDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [DIVDR_WIDTH-1:0] count,
   input  logic                   tx_fifo_empty,
   input  logic [FIFO_WIDTH-1:0]  tx_fifo_data,
   output logic                   tx_fifo_rd,
   output logic                   tx,
   output logic                   busy
);

   localparam int             IDX_W    = idx_width(FIFO_WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIFO_WIDTH - 1);

   upuart_tx_state_t       r_state;
   logic [FIFO_WIDTH-1:0]  r_data;
   logic [DIVDR_WIDTH-1:0] r_count;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_tx;
   logic                   r_busy;
   logic                   r_armed;
`ifdef UPUART_TX_PARITY_EN
   logic                   r_par;
`endif

   logic                   w_tick;
   logic                   w_pop;
   logic                   w_load;
   logic [DIVDR_WIDTH-1:0] w_load_val;
   logic [IDX_W-1:0]       w_idx_inc;

   // The pop has to coincide with the cycle the head word is observed, so it
   // is decoded from registered state rather than registered itself.
   // r_armed keeps the first cycle after reset release free of pops.
   assign w_pop = r_armed & ~tx_fifo_empty &
                  ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_tick));

   // A new bit starts on every pop and on every bit end inside a frame.
   assign w_load     = w_pop | ((r_state != ST_IDLE) & w_tick);
   assign w_load_val = w_pop ? count : r_count;
   assign w_idx_inc  = r_idx + IDX_W'(1);

   upuart_baud_tick #(
      .CNT_W (DIVDR_WIDTH)
   ) u_baud_tick (
      .clk        (clk),
      .nrst       (nrst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_tick     (w_tick)
   );

   // Frame sequencer; tx and busy are registered alongside the state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_count <= '0;
         r_idx   <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_armed <= 1'b0;
`ifdef UPUART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_armed <= 1'b1;
         if (w_pop) begin
            // Capture character and divider together; later divider changes
            // wait for the next character.
            r_data  <= tx_fifo_data;
            r_count <= count;
`ifdef UPUART_TX_PARITY_EN
            r_par   <= ^tx_fifo_data;
`endif
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_tx   <= 1'b1;
                  r_busy <= 1'b0;
               end
               ST_START: begin
                  if (w_tick) begin
                     r_state <= ST_DATA;
                     r_idx   <= '0;
                     r_tx    <= r_data[0];
                  end
               end
               ST_DATA: begin
                  if (w_tick) begin
                     if (r_idx == LAST_IDX) begin
`ifdef UPUART_TX_PARITY_EN
                        r_state <= ST_PARITY;
                        r_tx    <= r_par;
`else
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
`endif
                     end else begin
                        r_idx <= w_idx_inc;
                        r_tx  <= r_data[w_idx_inc];
                     end
                  end
               end
`ifdef UPUART_TX_PARITY_EN
               ST_PARITY: begin
                  if (w_tick) begin
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
                  end
               end
`endif
               ST_STOP: begin
                  if (w_tick) begin
                     r_state <= ST_IDLE;
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tx_fifo_rd = w_pop;
   assign tx         = r_tx;
   assign busy       = r_busy;

endmodule

// File: tb/tb_upuart_tx_ctrl.sv
// Directed bench for upuart_tx_ctrl with a queue-based FWFT FIFO model.
`timescale 1ns/1ps
module tb_upuart_tx_ctrl;

`ifdef UPUART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic [15:0] count = 16'd0;
   logic        tx_fifo_empty = 1'b1;
   logic [7:0]  tx_fifo_data = 8'h00;
   logic        tx_fifo_rd;
   logic        tx;
   logic        busy;

   logic [7:0]  q[$];
   int          pops = 0;
   int          n_err = 0;
   int          n_chk = 0;
   logic        rd_edge = 1'b0;

   upuart_tx_ctrl #(
      .FIFO_WIDTH  (8),
      .DIVDR_WIDTH (16)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .count         (count),
      .tx_fifo_empty (tx_fifo_empty),
      .tx_fifo_data  (tx_fifo_data),
      .tx_fifo_rd    (tx_fifo_rd),
      .tx            (tx),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      tx_fifo_empty = (q.size() == 0);
      tx_fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      refresh();
   endtask

   // One clock: sample the pop strobe before the edge, pop after it.
   task automatic step();
      @(negedge clk);
      rd_edge = tx_fifo_rd;
      @(posedge clk);
      #1;
      if (rd_edge) begin
         pops++;
         if (q.size() == 0) chk("rd_while_empty", 32'd1, 32'd0);
         else q.delete(0);
      end
      refresh();
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
`ifdef UPUART_TX_PARITY_EN
      if (j == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic wait_start(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (tx == 1'b0) break;
         step();
      end
      chk("start_seen", {31'd0, tx}, 32'd0);
   endtask

   // Check every cycle of a frame; optionally change count and push a
   // follow-up character at cycle chg_at.
   task automatic expect_frame(input logic [7:0] b, input int blen, input int chg_at,
                               input logic [15:0] chg_cnt, input logic [7:0] nxt);
      int n;
      n = 0;
      for (int j = 0; j < NB; j++) begin
         for (int k = 0; k < blen; k++) begin
            if (n == chg_at) begin
               count = chg_cnt;
               push(nxt);
            end
            chk($sformatf("tx_%02h_b%0d_c%0d", b, j, k), {31'd0, tx}, {31'd0, frame_bit(b, j)});
            chk($sformatf("busy_%02h_b%0d_c%0d", b, j, k), {31'd0, busy}, 32'd1);
            step();
            n++;
         end
      end
   endtask

   initial begin
      // Reset state
      #2 nrst = 1'b0;
      #1;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rd", {31'd0, tx_fifo_rd}, 32'd0);
      step();
      step();
      nrst = 1'b1;
      step();
      step();

      // FIFO empty for 100 cycles: no pop, line idle high
      pops = 0;
      for (int i = 0; i < 100; i++) begin
         chk($sformatf("idle_tx_%0d", i), {31'd0, tx}, 32'd1);
         step();
      end
      chk("idle_pops", pops, 0);

      // count=3, single 0x55 frame of 40 cycles
      count = 16'd3;
      pops  = 0;
      push(8'h55);
      wait_start(10);
      expect_frame(8'h55, 4, -1, 16'd0, 8'h00);
      chk("t1_tx_after", {31'd0, tx}, 32'd1);
      chk("t1_busy_after", {31'd0, busy}, 32'd0);
      chk("t1_pops", pops, 1);

      // count=0, two queued characters back to back
      count = 16'd0;
      pops  = 0;
      push(8'hA5);
      push(8'h3C);
      wait_start(10);
      expect_frame(8'hA5, 1, -1, 16'd0, 8'h00);
      expect_frame(8'h3C, 1, -1, 16'd0, 8'h00);
      chk("t2_tx_after", {31'd0, tx}, 32'd1);
      chk("t2_busy_after", {31'd0, busy}, 32'd0);
      chk("t2_pops", pops, 2);

      // count=2, change to 9 during DATA: next character uses 10-cycle bits
      count = 16'd2;
      pops  = 0;
      push(8'h0F);
      wait_start(10);
      expect_frame(8'h0F, 3, 12, 16'd9, 8'hC3);
      expect_frame(8'hC3, 10, -1, 16'd0, 8'h00);
      chk("t3_tx_after", {31'd0, tx}, 32'd1);
      chk("t3_busy_after", {31'd0, busy}, 32'd0);
      chk("t3_pops", pops, 2);

      // count=5, reset in the middle of DATA
      count = 16'd5;
      push(8'h00);
      wait_start(10);
      for (int i = 0; i < 15; i++) step();
      chk("t4_tx_pre_rst", {31'd0, tx}, 32'd0);
      chk("t4_busy_pre_rst", {31'd0, busy}, 32'd1);
      nrst = 1'b0;
      #1;
      chk("t4_tx_async", {31'd0, tx}, 32'd1);
      chk("t4_busy_async", {31'd0, busy}, 32'd0);
      step();
      nrst = 1'b1;
      pops = 0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t4_tx_rel_%0d", i), {31'd0, tx}, 32'd1);
         step();
      end
      chk("t4_pops_empty", pops, 0);

      // Reset release with a character waiting: no pop in the first cycle
      nrst = 1'b0;
      #1;
      push(8'h81);
      step();
      step();
      chk("t4_pops_in_rst", pops, 0);
      nrst = 1'b1;
      step();
      chk("t4_no_pop_first", {31'd0, rd_edge}, 32'd0);
      wait_start(10);
      expect_frame(8'h81, 6, -1, 16'd0, 8'h00);
      chk("t4_pops_after", pops, 1);
      chk("t4_busy_after", {31'd0, busy}, 32'd0);

`ifdef UPUART_TX_PARITY_EN
      // count=1: parity 1 for 0x07, parity 0 for 0x03, 22-cycle frames
      count = 16'd1;
      pops  = 0;
      push(8'h07);
      push(8'h03);
      wait_start(10);
      expect_frame(8'h07, 2, -1, 16'd0, 8'h00);
      expect_frame(8'h03, 2, -1, 16'd0, 8'h00);
      chk("t5_pops", pops, 2);
      chk("t5_busy_after", {31'd0, busy}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/upuart_tx_ctrl.md
UPUART_TX_CTRL -- requirements
Module: upuart_tx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, character width in bits.
REQ-002 SHALL have parameter DIVDR_WIDTH, default 16, width of the baud divider input.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port count  input  DIVDR_WIDTH  baud divider; one bit period = count+1 clk cycles.
REQ-006 SHALL have port tx_fifo_empty  input  1  TX FIFO empty flag.
REQ-007 SHALL have port tx_fifo_data  input  FIFO_WIDTH  TX FIFO head word, valid whenever tx_fifo_empty=0 (first-word fall-through).
REQ-008 SHALL have port tx_fifo_rd  output  1  one-cycle pop strobe to the TX FIFO.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a character is held or being shifted.

Function
REQ-011 SHALL implement states IDLE, START, DATA, [PARITY], STOP.
REQ-012 IDLE: when tx_fifo_empty=0, SHALL assert tx_fifo_rd for exactly one cycle, latch tx_fifo_data and count in that cycle, and enter START next cycle.
REQ-013 START SHALL drive tx=0 for count_latched+1 cycles.
REQ-014 DATA SHALL drive FIFO_WIDTH bits LSB first, each for count_latched+1 cycles; a bit index counter of ceil(log2(FIFO_WIDTH)) bits SHALL select the bit, no wrap beyond FIFO_WIDTH-1.
REQ-015 STOP SHALL drive tx=1 for count_latched+1 cycles.
REQ-016 In the last STOP cycle, if tx_fifo_empty=0, SHALL pop and latch (as REQ-012) and enter START next cycle (zero idle gap); otherwise SHALL enter IDLE.
REQ-017 The bit-period counter SHALL load count_latched at each bit start and decrement to 0; count=0 SHALL give one-cycle bits.
REQ-018 Changes on count mid-frame SHALL NOT affect the current frame; they SHALL take effect at the next pop.
REQ-019 tx_fifo_rd SHALL never assert while tx_fifo_empty=1 nor outside IDLE or the last STOP cycle.
REQ-020 busy SHALL be 1 from the cycle after a pop through the last STOP cycle, and 0 in IDLE.
REQ-021 tx SHALL be driven from a register (glitch-free).

Reset
REQ-022 On nrst=0, SHALL immediately force tx=1, busy=0, tx_fifo_rd=0, state=IDLE, counters and latched data to 0.
REQ-023 Reset mid-frame SHALL abandon the character; no pop SHALL occur in the first cycle after reset release.

Configuration
REQ-024 With UPUART_TX_PARITY_EN defined, SHALL insert PARITY state after DATA driving even parity (XOR of data bits) for count_latched+1 cycles.
REQ-025 Without UPUART_TX_PARITY_EN, SHALL omit PARITY state; DATA proceeds directly to STOP; no parity logic SHALL be synthesized.

Structure
REQ-026 State encoding constants and default FIFO_WIDTH/DIVDR_WIDTH SHALL reside in shared package upuart_pkg.
REQ-027 Bit-period down-counter SHALL be sub-module upuart_baud_tick (inputs load, load value; output tick at zero).

Verification
REQ-028 count=3, push 0x55, parity off -> single tx_fifo_rd pulse; tx = 0,1,0,1,0,1,0,1,0,1 each 4 cycles (40-cycle frame); busy high 40 cycles.
REQ-029 count=0, push 0xA5 and 0x3C before start -> two pops, frames 10 cycles each, second START immediately follows first STOP (no tx=1 gap beyond stop bit).
REQ-030 count=2, push 0x0F, change count to 9 during DATA -> whole frame uses 3-cycle bits; next character uses 10-cycle bits.
REQ-031 count=5, assert nrst=0 mid DATA -> tx=1, busy=0 same cycle; after release with FIFO empty, tx stays 1, no pop.
REQ-032 UPUART_TX_PARITY_EN defined, count=1, push 0x07 -> parity bit=1, push 0x03 -> parity bit=0; frames 22 cycles.
REQ-033 FIFO empty for 100 cycles -> tx_fifo_rd never asserted, tx constant 1.
